// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and the memory responder (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        pcOrData;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, pcOrData, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, pcOrData, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM target: one request in flight, response pulse WAIT_CYCLES+1 cycles after accept.
// req_ready is low while busy or while the loader writes; the loader wins any collision in IDLE.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    mem_responder_if.slave    bus,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [15:0]       ld_data_i,
    output logic [15:0]       fetch_cnt_o,
    output logic [15:0]       load_cnt_o,
    output logic [15:0]       store_cnt_o
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              we_q, pc_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [15:0]       fetch_q, fetch_d, load_q, load_d, store_q, store_d;
    logic [15:0]       mem [DEPTH];

    logic              idle, accept, req_err, enter_resp;
    logic              cur_we, cur_pc, cur_err;
    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       cur_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;

    assign idle          = (state_q == S_IDLE);
    assign bus.req_ready = idle && !ld_we_i;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_err       = ((bus.req_addr >> ADDR_W) != 16'd0) || (bus.pcOrData && bus.req_we);

    // With zero wait states RESP is entered straight from IDLE, so use the live request there.
    assign cur_we    = idle ? bus.req_we                 : we_q;
    assign cur_pc    = idle ? bus.pcOrData               : pc_q;
    assign cur_err   = idle ? req_err                    : err_q;
    assign cur_addr  = idle ? bus.req_addr[ADDR_W-1:0]   : addr_q;
    assign cur_wdata = idle ? bus.req_wdata              : wdata_q;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;
        fetch_d    = fetch_q;
        load_d     = load_q;
        store_d    = store_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ld_addr_i;
        mem_wdata  = ld_data_i;

        case (state_q)
            S_IDLE: begin
                if (ld_we_i) begin
                    mem_we = 1'b1;
                end else if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            rerr_d  = cur_err;
            rdata_d = (cur_err || cur_we) ? 16'd0 : mem[cur_addr];
            if (!cur_err) begin
                if (cur_pc) begin
                    fetch_d = fetch_q + 16'd1;
                end else if (cur_we) begin
                    store_d   = store_q + 16'd1;
                    mem_we    = 1'b1;
                    mem_waddr = cur_addr;
                    mem_wdata = cur_wdata;
                end else begin
                    load_d = load_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            rdata_q <= 16'd0;
            rerr_q  <= 1'b0;
            fetch_q <= 16'd0;
            load_q  <= 16'd0;
            store_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            fetch_q <= fetch_d;
            load_q  <= load_d;
            store_q <= store_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= bus.req_we;
            pc_q    <= bus.pcOrData;
            err_q   <= req_err;
            addr_q  <= bus.req_addr[ADDR_W-1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    // RAM survives reset, but a reset edge must never land a pending write.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = rerr_q;
    assign fetch_cnt_o    = fetch_q;
    assign load_cnt_o     = load_q;
    assign store_cnt_o    = store_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against an array-based memory model.
module tb_mem_responder;
    localparam int AW = 8;
    localparam int W  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus();
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic [15:0]   fetch_cnt, load_cnt, store_cnt;

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .bus         (bus),
        .ld_we_i     (ld_we),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data),
        .fetch_cnt_o (fetch_cnt),
        .load_cnt_o  (load_cnt),
        .store_cnt_o (store_cnt)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_cur;
    logic [15:0] ref_mem [256];
    logic [15:0] m_fetch = 0, m_load = 0, m_store = 0;
    int          tests = 0, fails = 0;
    int          cyc = 0;
    logic [15:0] last_rd = 0;
    logic        last_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_counts();
        check("fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_fetch});
        check("load_cnt",  {16'd0, load_cnt},  {16'd0, m_load});
        check("store_cnt", {16'd0, store_cnt}, {16'd0, m_store});
    endtask

    // Monitor: every response pulse is matched against the scoreboard; between pulses outputs hold.
    always @(negedge clk) begin
        if (reset) begin
            last_rd  = 16'd0;
            last_err = 1'b0;
        end else if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: pulse at cycle %0d, none expected", cyc);
            end else begin
                e_cur = exp_q.pop_front();
                check("resp_cycle", cyc, e_cur.at);
                check("resp_rdata", {16'd0, bus.resp_rdata}, {16'd0, e_cur.rdata});
                check("resp_err", {31'd0, bus.resp_err}, {31'd0, e_cur.err});
            end
            last_rd  = bus.resp_rdata;
            last_err = bus.resp_err;
        end else begin
            check("hold_rdata", {16'd0, bus.resp_rdata}, {16'd0, last_rd});
            check("hold_err", {31'd0, bus.resp_err}, {31'd0, last_err});
        end
    end

    task automatic ld(input logic [AW-1:0] a, input logic [15:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        ref_mem[a] = d;
        #1 ld_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic pc, input logic [15:0] addr,
                          input logic [15:0] wdata, input bit collide, input bit busy_ld);
        int          acc;
        logic        err;
        logic [15:0] rd;
        bus.req_valid = 1'b1; bus.req_we = we; bus.pcOrData = pc;
        bus.req_addr = addr; bus.req_wdata = wdata;
        if (collide) begin
            ld_we = 1'b1; ld_addr = AW'($urandom); ld_data = 16'($urandom);
            @(negedge clk);
            check("ready_collide", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk);
            ref_mem[ld_addr] = ld_data;
            #1 ld_we = 1'b0;
        end
        @(negedge clk);
        check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 acc = cyc;
        err = ((addr >> AW) != 16'd0) || (pc && we);
        rd  = (err || we) ? 16'd0 : ref_mem[addr[AW-1:0]];
        if (!err) begin
            if (pc)      m_fetch++;
            else if (we) begin m_store++; ref_mem[addr[AW-1:0]] = wdata; end
            else         m_load++;
        end
        exp_q.push_back('{rd, err, acc + W});
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom); bus.pcOrData = 1'($urandom);
        bus.req_addr = 16'($urandom); bus.req_wdata = 16'($urandom);
        if (busy_ld) begin
            ld_we = 1'b1; ld_addr = addr[AW-1:0]; ld_data = 16'($urandom);
        end
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk);
            #1 ld_we = 1'b0;
        end
        check_counts();
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.pcOrData = 1'b0;
        bus.req_addr = 16'd0; bus.req_wdata = 16'd0;
        ld_we = 1'b0; ld_addr = '0; ld_data = 16'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check_counts();

        for (int i = 0; i < 256; i++) ld(AW'(i), 16'($urandom));
        ld(8'd5, 16'h1234);
        ld(8'd7, 16'h0001);

        do_req(1'b0, 1'b1, 16'd5, 16'd0, 0, 0);          // fetch after preload
        do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, 0, 0);    // store then load
        do_req(1'b0, 1'b0, 16'h0010, 16'd0, 0, 0);
        do_req(1'b1, 1'b0, 16'h0100, 16'hAAAA, 0, 0);    // out of range
        do_req(1'b0, 1'b0, 16'h0100, 16'd0, 0, 0);
        do_req(1'b0, 1'b0, 16'h0000, 16'd0, 0, 0);
        do_req(1'b1, 1'b1, 16'd3, 16'h7777, 0, 0);       // store tagged as fetch
        do_req(1'b0, 1'b0, 16'd3, 16'd0, 0, 0);
        do_req(1'b0, 1'b0, 16'd9, 16'd0, 1, 0);          // loader collision
        do_req(1'b1, 1'b0, 16'd9, 16'h4321, 0, 1);       // loader ignored while busy
        do_req(1'b0, 1'b0, 16'd9, 16'd0, 0, 0);

        // Reset during WAIT aborts a store.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.pcOrData = 1'b0;
        bus.req_addr = 16'd7; bus.req_wdata = 16'h5555;
        @(negedge clk);
        check("ready_pre_abort", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_fetch = 0; m_load = 0; m_store = 0;
        @(negedge clk);
        check("ready_post_abort", {31'd0, bus.req_ready}, 32'd1);
        check_counts();
        repeat (W + 2) @(posedge clk);
        #1 do_req(1'b0, 1'b0, 16'd7, 16'd0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            do_req(1'($urandom), 1'($urandom), a, 16'($urandom),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
